cdma_rx_multiuser: RTL and testbench
====================================

// Module: cdma_rx_multiuser
// PURPOSE
// Parametrised multi-user CDMA receiver and router. It accepts a stream of signed, summed chip samples and
// correlates each symbol against NUM_USERS Walsh-Hadamard codes. Recovered bits are packed into per-user words
// and buffered in per-user FIFOs. A round-robin arbiter drains the FIFOs onto a single valid/ready output tagged
// with the user index. Successor to the fixed 4-user receiver: adds configurable users/chip length, chip-level
// accumulation, erasure detection, overflow status and output backpressure.
// PARAMETERS
// NUM_USERS      4  user channels; 2..CHIP_LEN
// CHIP_LEN       8  chips per symbol; power of 2, >=2
// SAMPLE_W       4  signed chip sample width
// BITS_PER_WORD  4  decoded bits packed per output word
// FIFO_DEPTH     4  words per user FIFO; power of 2, >=2
// PORTS
// clk         in   1                    clock, all logic on rising edge
// rst         in   1                    synchronous, active-high reset
// chip_in     in   SAMPLE_W             signed chip sample (two's complement)
// chip_valid  in   1                    chip_in valid this cycle
// frame_sync  in   1                    with chip_valid: this chip is chip 0 of bit 0 of a new word
// out_data    out  BITS_PER_WORD        decoded word; bit n = nth symbol of word
// out_user    out  $clog2(NUM_USERS)    user index of out_data
// out_erasure out  1                    >=1 symbol in word had zero correlation
// out_valid   out  1                    output register holds a word
// out_ready   in   1                    consumer accepts when out_valid && out_ready
// overflow    out  NUM_USERS            sticky per-user FIFO-overflow flags
// BEHAVIOUR
// - Reset: all outputs 0; chip_idx=0, bit_idx=0, accumulators/word regs/FIFOs cleared, rr_ptr=0. Reset mid-symbol discards all partial and buffered data.
// - Code: user k, chip i: c = parity(k & i); c=0 -> +1, c=1 -> -1 (Hadamard row k).
// - ACC_W = SAMPLE_W+$clog2(CHIP_LEN)+1, signed, no saturation needed.
// - Per accepted chip: acc_k += c ? -chip_in : chip_in; chip_idx increments. Cycles without chip_valid hold all state.
// - chip_idx==CHIP_LEN-1: final sum S_k = acc_k + contribution; bit = (S_k>0); S_k==0 -> bit 0, set word erasure flag. Bit written into word position bit_idx; acc_k cleared; chip_idx->0, bit_idx++.
// - frame_sync && chip_valid: chip treated as chip 0, bit 0; acc_k loaded with this chip only; partial word and erasure flags discarded.
// - Word complete (last chip of bit BITS_PER_WORD-1): on that same edge {erasure,word} written to each user FIFO; bit_idx->0.
// - FIFO full at write: word dropped, overflow[k] set (sticky until rst). Full FIFO popped same edge: write accepted, no overflow.
// - Output reg loads when (!out_valid || out_ready) and any FIFO non-empty: grant first non-empty user searching from rr_ptr upward (wrap); pop it; rr_ptr <= grant+1 mod NUM_USERS.
// - Latency: word visible on out_* 1 cycle after the edge that completed it (empty FIFO, output idle).
// - out_valid && !out_ready: out_data/out_user/out_erasure held stable; no FIFO pops.
// - Throughput: one word per cycle at output with out_ready held high.
// TESTING (CHIP_LEN=4, NUM_USERS=4, SAMPLE_W=4, BITS_PER_WORD=4)
// 1. rst, then chips [4,0,0,0] x4 symbols with frame_sync on first -> users 0..3 emit 4'hF in order 0,1,2,3, erasure 0, out_valid first seen 1 cycle after last chip.
// 2. Chips [0,4,0,0] x4 -> words u0=F,u1=0,u2=F,u3=0; chips [0,0,0,0] one symbol within word -> erasure=1 for all users.
// 3. out_ready=0 for 6 words per user (depth 4) -> overflow=4'hF, first 4 words/user retained, drained in RR order with data stable while stalled.
// 4. frame_sync mid-word (after 2 symbols) -> partial word discarded; next word built from new frame only.
// 5. chip_valid gaps of 1-3 cycles between chips -> identical words to gap-free run.
// 6. rst asserted mid-symbol with FIFOs non-empty -> next cycle out_valid=0, overflow=0, and next frame decodes correctly.

Source files
------------

// File: rtl/cdma_rx_multiuser.sv
// Multi-user CDMA receiver: Walsh-Hadamard despreading of a summed chip stream,
// per-user word packing and FIFOs, round-robin drain onto one valid/ready port.
module cdma_rx_multiuser #(
    parameter int NUM_USERS     = 4,
    parameter int CHIP_LEN      = 8,
    parameter int SAMPLE_W      = 4,
    parameter int BITS_PER_WORD = 4,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [SAMPLE_W-1:0]   chip_in,
    input  logic                         chip_valid,
    input  logic                         frame_sync,
    output logic [BITS_PER_WORD-1:0]     out_data,
    output logic [$clog2(NUM_USERS)-1:0] out_user,
    output logic                         out_erasure,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_USERS-1:0]         overflow
);
    localparam int UW    = $clog2(NUM_USERS);
    localparam int CW    = $clog2(CHIP_LEN);
    localparam int BW    = (BITS_PER_WORD > 1) ? $clog2(BITS_PER_WORD) : 1;
    localparam int ACC_W = SAMPLE_W + CW + 1;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int EW    = BITS_PER_WORD + 1;
    localparam logic signed [ACC_W-1:0] ACC_ZERO = '0;

    logic [CW-1:0]              chip_idx, eff_chip;
    logic [BW-1:0]              bit_idx, eff_bit;
    logic                       sym_done, word_done;
    logic signed [ACC_W-1:0]    chip_ext, base;
    logic signed [ACC_W-1:0]    acc        [NUM_USERS];
    logic signed [ACC_W-1:0]    sum        [NUM_USERS];
    logic [BITS_PER_WORD-1:0]   word       [NUM_USERS];
    logic [BITS_PER_WORD-1:0]   word_keep  [NUM_USERS];
    logic [BITS_PER_WORD-1:0]   word_nxt   [NUM_USERS];
    logic                       erase      [NUM_USERS];
    logic                       erase_keep [NUM_USERS];
    logic                       erase_nxt  [NUM_USERS];

    logic [EW-1:0]              fifo_mem   [NUM_USERS][FIFO_DEPTH];
    logic [AW-1:0]              wr_ptr     [NUM_USERS];
    logic [AW-1:0]              rd_ptr     [NUM_USERS];
    logic [AW:0]                fifo_cnt   [NUM_USERS];
    logic [NUM_USERS-1:0]       fifo_full, fifo_nonempty, push_ok, pop;

    logic [UW-1:0]              rr_ptr, grant, scan;
    logic                       grant_found, load;

    // frame_sync forces the current chip to be chip 0 of bit 0 and drops partial state
    always_comb begin
        eff_chip  = frame_sync ? '0 : chip_idx;
        eff_bit   = frame_sync ? '0 : bit_idx;
        sym_done  = chip_valid && (eff_chip == CW'(CHIP_LEN - 1));
        word_done = sym_done && (eff_bit == BW'(BITS_PER_WORD - 1));
        chip_ext  = {{(ACC_W - SAMPLE_W){chip_in[SAMPLE_W-1]}}, chip_in};
        base      = '0;
        for (int unsigned k = 0; k < NUM_USERS; k++) begin
            base = frame_sync ? ACC_ZERO : acc[k];
            if (^(CW'(k) & eff_chip))
                sum[k] = base - chip_ext;
            else
                sum[k] = base + chip_ext;
            word_keep[k]          = frame_sync ? '0 : word[k];
            erase_keep[k]         = frame_sync ? 1'b0 : erase[k];
            word_nxt[k]           = word_keep[k];
            word_nxt[k][eff_bit]  = (sum[k] > ACC_ZERO);
            erase_nxt[k]          = erase_keep[k] | (sum[k] == ACC_ZERO);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            chip_idx <= '0;
            bit_idx  <= '0;
            for (int unsigned k = 0; k < NUM_USERS; k++) begin
                acc[k]   <= '0;
                word[k]  <= '0;
                erase[k] <= 1'b0;
            end
        end else if (chip_valid) begin
            if (sym_done) begin
                chip_idx <= '0;
                bit_idx  <= word_done ? '0 : eff_bit + 1'b1;
                for (int unsigned k = 0; k < NUM_USERS; k++) begin
                    acc[k]   <= '0;
                    word[k]  <= word_done ? '0 : word_nxt[k];
                    erase[k] <= word_done ? 1'b0 : erase_nxt[k];
                end
            end else begin
                chip_idx <= eff_chip + 1'b1;
                bit_idx  <= eff_bit;
                for (int unsigned k = 0; k < NUM_USERS; k++) begin
                    acc[k]   <= sum[k];
                    word[k]  <= word_keep[k];
                    erase[k] <= erase_keep[k];
                end
            end
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < NUM_USERS; k++) begin
            fifo_full[k]     = (fifo_cnt[k] == (AW + 1)'(FIFO_DEPTH));
            fifo_nonempty[k] = (fifo_cnt[k] != '0);
        end
    end

    // Round-robin scan starting at rr_ptr; a pop frees space for a same-edge push
    always_comb begin
        grant       = '0;
        grant_found = 1'b0;
        scan        = '0;
        for (int unsigned i = 0; i < NUM_USERS; i++) begin
            scan = UW'((32'(rr_ptr) + i) % NUM_USERS);
            if (!grant_found && fifo_nonempty[scan]) begin
                grant       = scan;
                grant_found = 1'b1;
            end
        end
        load = (!out_valid || out_ready) && grant_found;
        pop  = '0;
        if (load)
            pop[grant] = 1'b1;
        for (int unsigned k = 0; k < NUM_USERS; k++)
            push_ok[k] = word_done && (!fifo_full[k] || pop[k]);
    end

    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < NUM_USERS; k++)
            if (!rst && push_ok[k])
                fifo_mem[k][wr_ptr[k]] <= {erase_nxt[k], word_nxt[k]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= '0;
            for (int unsigned k = 0; k < NUM_USERS; k++) begin
                wr_ptr[k]   <= '0;
                rd_ptr[k]   <= '0;
                fifo_cnt[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < NUM_USERS; k++) begin
                if (push_ok[k])
                    wr_ptr[k] <= wr_ptr[k] + 1'b1;
                if (pop[k])
                    rd_ptr[k] <= rd_ptr[k] + 1'b1;
                if (push_ok[k] && !pop[k])
                    fifo_cnt[k] <= fifo_cnt[k] + 1'b1;
                else if (!push_ok[k] && pop[k])
                    fifo_cnt[k] <= fifo_cnt[k] - 1'b1;
                if (word_done && fifo_full[k] && !pop[k])
                    overflow[k] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_user    <= '0;
            out_erasure <= 1'b0;
            rr_ptr      <= '0;
        end else if (load) begin
            {out_erasure, out_data} <= fifo_mem[grant][rd_ptr[grant]];
            out_user  <= grant;
            out_valid <= 1'b1;
            rr_ptr    <= (grant == UW'(NUM_USERS - 1)) ? '0 : grant + 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_cdma_rx_multiuser.sv
// Bench for cdma_rx_multiuser: directed scenarios plus random traffic, checked
// every cycle against a queue-based behavioural model.
module tb_cdma_rx_multiuser;
    localparam int NU  = 4;
    localparam int CL  = 4;
    localparam int SW  = 4;
    localparam int BPW = 4;
    localparam int FD  = 4;

    logic                 clk = 1'b0;
    logic                 rst, chip_valid, frame_sync, out_ready;
    logic signed [SW-1:0] chip_in;
    logic [BPW-1:0]       out_data;
    logic [1:0]           out_user;
    logic                 out_erasure, out_valid;
    logic [NU-1:0]        overflow;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cdma_rx_multiuser #(
        .NUM_USERS(NU), .CHIP_LEN(CL), .SAMPLE_W(SW),
        .BITS_PER_WORD(BPW), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst(rst), .chip_in(chip_in), .chip_valid(chip_valid),
        .frame_sync(frame_sync), .out_data(out_data), .out_user(out_user),
        .out_erasure(out_erasure), .out_valid(out_valid), .out_ready(out_ready),
        .overflow(overflow)
    );

    // Behavioural model: chip list per symbol, bit list per word, queue per user
    int             sym_chips[$];
    int             m_nbits;
    logic [BPW-1:0] m_word [NU];
    logic           m_er   [NU];
    logic [BPW:0]   m_q    [NU][$];
    logic           m_valid, m_erasure;
    logic [BPW-1:0] m_data;
    int             m_user, m_rr;
    logic [NU-1:0]  m_ovf;

    task automatic model_reset();
        sym_chips.delete();
        m_nbits = 0;
        for (int k = 0; k < NU; k++) begin
            m_word[k] = '0;
            m_er[k]   = 1'b0;
            m_q[k].delete();
        end
        m_valid = 1'b0; m_erasure = 1'b0; m_data = '0;
        m_user = 0; m_rr = 0; m_ovf = '0;
    endtask

    task automatic model_step();
        bit           found = 0;
        int           g = 0;
        int           s;
        logic [BPW:0] e;
        if (rst) begin
            model_reset();
            return;
        end
        if (!m_valid || out_ready) begin
            for (int i = 0; i < NU; i++) begin
                int u = (m_rr + i) % NU;
                if (!found && m_q[u].size() > 0) begin found = 1; g = u; end
            end
            if (found) begin
                e = m_q[g].pop_front();
                m_data = e[BPW-1:0]; m_erasure = e[BPW];
                m_user = g; m_valid = 1'b1; m_rr = (g + 1) % NU;
            end else begin
                m_valid = 1'b0;
            end
        end
        if (chip_valid) begin
            if (frame_sync) begin
                sym_chips.delete();
                m_nbits = 0;
                for (int k = 0; k < NU; k++) begin m_word[k] = '0; m_er[k] = 1'b0; end
            end
            sym_chips.push_back(int'(chip_in));
            if (sym_chips.size() == CL) begin
                for (int k = 0; k < NU; k++) begin
                    s = 0;
                    for (int i = 0; i < CL; i++)
                        s += ($countones(k & i) % 2 == 1) ? -sym_chips[i] : sym_chips[i];
                    m_word[k][m_nbits] = (s > 0);
                    if (s == 0) m_er[k] = 1'b1;
                end
                sym_chips.delete();
                m_nbits++;
                if (m_nbits == BPW) begin
                    for (int k = 0; k < NU; k++) begin
                        if (m_q[k].size() < FD) m_q[k].push_back({m_er[k], m_word[k]});
                        else m_ovf[k] = 1'b1;
                        m_word[k] = '0; m_er[k] = 1'b0;
                    end
                    m_nbits = 0;
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("out_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid) begin
            check("out_data", 32'(out_data), 32'(m_data));
            check("out_user", 32'(out_user), m_user);
            check("out_erasure", 32'(out_erasure), 32'(m_erasure));
        end
        check("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic chip(input int v, input bit fs, input int gap);
        repeat (gap) tick();
        chip_valid = 1'b1; chip_in = v[SW-1:0]; frame_sync = fs;
        tick();
        chip_valid = 1'b0; frame_sync = 1'b0;
    endtask

    task automatic sym(input int a0, input int a1, input int a2, input int a3,
                       input bit fs, input int maxgap);
        chip(a0, fs, (maxgap > 0) ? $urandom_range(1, maxgap) : 0);
        chip(a1, 0, (maxgap > 0) ? $urandom_range(1, maxgap) : 0);
        chip(a2, 0, (maxgap > 0) ? $urandom_range(1, maxgap) : 0);
        chip(a3, 0, (maxgap > 0) ? $urandom_range(1, maxgap) : 0);
    endtask

    logic [BPW-1:0] t2_exp [NU];

    initial begin
        t2_exp = '{4'hF, 4'h0, 4'hF, 4'h0};
        model_reset();
        rst = 1'b1; chip_valid = 1'b0; frame_sync = 1'b0; out_ready = 1'b1; chip_in = '0;
        tick(); tick();
        rst = 1'b0;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);

        // Energy on chip 0 only: every user decodes 1
        for (int s = 0; s < BPW; s++) sym(4, 0, 0, 0, s == 0, 0);
        check("t1_latency", 32'(out_valid), 32'd0);
        for (int u = 0; u < NU; u++) begin
            tick();
            check("t1_valid", 32'(out_valid), 32'd1);
            check("t1_user", 32'(out_user), u);
            check("t1_data", 32'(out_data), 32'hF);
            check("t1_erasure", 32'(out_erasure), 32'd0);
        end

        // Chip 1 energy separates even and odd Hadamard rows
        for (int s = 0; s < BPW; s++) sym(0, 4, 0, 0, 0, 0);
        for (int u = 0; u < NU; u++) begin
            tick();
            check("t2_user", 32'(out_user), u);
            check("t2_data", 32'(out_data), 32'(t2_exp[u]));
        end
        sym(4, 0, 0, 0, 0, 0); sym(0, 0, 0, 0, 0, 0);
        sym(4, 0, 0, 0, 0, 0); sym(4, 0, 0, 0, 0, 0);
        for (int u = 0; u < NU; u++) begin
            tick();
            check("t2_erasure", 32'(out_erasure), 32'd1);
            check("t2_erdata", 32'(out_data), 32'hD);
        end
        tick();

        // Stalled output: six words per user into depth-4 FIFOs
        out_ready = 1'b0;
        for (int w = 0; w < 6 * BPW; w++)
            sym($urandom_range(0, 15) - 8, $urandom_range(0, 15) - 8,
                $urandom_range(0, 15) - 8, $urandom_range(0, 15) - 8, 0, 0);
        check("t3_overflow", 32'(overflow), 32'hF);
        repeat (5) tick();
        out_ready = 1'b1;
        repeat (20) tick();
        check("t3_drained", 32'(out_valid), 32'd0);

        // frame_sync after two symbols abandons the partial word
        sym(4, 0, 0, 0, 1, 0); sym(4, 0, 0, 0, 0, 0);
        for (int s = 0; s < BPW; s++) sym(-4, 0, 0, 0, s == 0, 0);
        for (int u = 0; u < NU; u++) begin
            tick();
            check("t4_data", 32'(out_data), 32'h0);
            check("t4_erasure", 32'(out_erasure), 32'd0);
        end

        // Idle gaps between chips must not change the decode
        for (int s = 0; s < BPW; s++) sym(4, 0, 0, 0, s == 0, 3);
        for (int u = 0; u < NU; u++) begin
            tick();
            check("t5_valid", 32'(out_valid), 32'd1);
            check("t5_data", 32'(out_data), 32'hF);
        end
        for (int s = 0; s < BPW; s++)
            sym($urandom_range(0, 15) - 8, $urandom_range(0, 15) - 8,
                $urandom_range(0, 15) - 8, $urandom_range(0, 15) - 8, s == 0, 3);
        repeat (6) tick();

        // Reset mid-symbol with buffered words and sticky overflow
        out_ready = 1'b0;
        for (int s = 0; s < BPW; s++) sym(4, 0, 0, 0, s == 0, 0);
        tick();
        chip(4, 0, 0); chip(0, 0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_valid", 32'(out_valid), 32'd0);
        check("t6_overflow", 32'(overflow), 32'd0);
        out_ready = 1'b1;
        for (int s = 0; s < BPW; s++) sym(4, 0, 0, 0, s == 0, 0);
        for (int u = 0; u < NU; u++) begin
            tick();
            check("t6_user", 32'(out_user), u);
            check("t6_data", 32'(out_data), 32'hF);
        end

        // Random traffic with random backpressure and occasional resync
        for (int n = 0; n < 600; n++) begin
            chip_valid = ($urandom_range(0, 3) != 0);
            chip_in    = SW'($urandom_range(0, 15));
            frame_sync = chip_valid && ($urandom_range(0, 59) == 0);
            out_ready  = ($urandom_range(0, 3) != 0);
            tick();
        end
        chip_valid = 1'b0; frame_sync = 1'b0; out_ready = 1'b1;
        repeat (24) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
